// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   addr_width()  : address width for a given register count
//   addr_w        : address width of the default 32-entry file
//   x0            : index of the hardwired-zero register
//   port_field()  : extracts port idx (w bits wide) from a flattened port bus
package regfile_pkg;

  localparam int nregs_default = 32;
  localparam int addr_w        = $clog2(nregs_default);
  localparam int x0            = 0;

  // Flattened buses are zero-extended to max_flat before slicing;
  // fields up to max_field bits wide can be extracted.
  localparam int max_flat  = 4096;
  localparam int max_field = 128;

  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  function automatic logic [max_field-1:0] port_field(
    input logic [max_flat-1:0] vec,
    input int                  idx,
    input int                  w
  );
    logic [max_flat-1:0]  sh;
    logic [max_field-1:0] mask;
    sh   = vec >> (idx * w);
    // w == max_field shifts the 1 out, and 0 - 1 yields the full mask.
    mask = (max_field'(1) << w) - max_field'(1);
    return max_field'(sh) & mask;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Port bundle of the multi-port register file.
//   read side : rs_addr -> rs_data / rs_busy (combinational)
//   write side: rd_addr, rd_data, write_en (writeback)
//   reserve   : rsv_en, rsv_addr -> rsv_ok (issue)
// master = core side, slave = register file.
interface register_file_mp_if #(
  parameter int xlen   = 64,
  parameter int nregs  = 32,
  parameter int nread  = 2,
  parameter int nwrite = 2
) ();
  localparam int aw = $clog2(nregs);

  logic [nread*aw-1:0]    rs_addr;
  logic [nread*xlen-1:0]  rs_data;
  logic [nread-1:0]       rs_busy;
  logic [nwrite*aw-1:0]   rd_addr;
  logic [nwrite*xlen-1:0] rd_data;
  logic [nwrite-1:0]      write_en;
  logic                   rsv_en;
  logic [aw-1:0]          rsv_addr;
  logic                   rsv_ok;

  modport master (
    output rs_addr, rd_addr, rd_data, write_en, rsv_en, rsv_addr,
    input  rs_data, rs_busy, rsv_ok
  );
  modport slave (
    input  rs_addr, rd_addr, rd_data, write_en, rsv_en, rsv_addr,
    output rs_data, rs_busy, rsv_ok
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an in-flight result.
//   write_en/wr_addr : writeback ports, clear the target's busy bit
//   rsv_en/rsv_addr  : reserve request, sets the busy bit when rsv_ok
//   busy             : current busy vector (bit x0 always 0)
//   rsv_ok           : reserve accepted (target idle, or x0)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int nregs  = 32,
  parameter int nwrite = 2,
  parameter int aw     = $clog2(nregs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [nwrite-1:0]          write_en,
  input  logic [nwrite-1:0][aw-1:0]  wr_addr,
  input  logic                       rsv_en,
  input  logic [aw-1:0]              rsv_addr,
  output logic [nregs-1:0]           busy,
  output logic                       rsv_ok
);

  logic [nregs-1:0] busy_nxt;

  // Refusing a reserve on a busy target stalls issue on a WAW hazard.
  assign rsv_ok = !busy[rsv_addr] || (rsv_addr == aw'(x0));

  // Clears first, then the reserve, so a new producer issued in the cycle
  // the old one retires keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < nwrite; j++)
      if (write_en[j]) busy_nxt[wr_addr[j]] = 1'b0;
    if (rsv_en && rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[x0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with busy scoreboard.
//   clk, rst : clock, synchronous active-high reset
//   bus      : register_file_mp_if.slave (read, write, reserve ports)
// Reads are combinational; with bypass=1 a same-cycle write to the read
// address is forwarded and reported not-busy. Highest write port wins.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int xlen   = 64,
  parameter int nregs  = 32,
  parameter int nread  = 2,
  parameter int nwrite = 2,
  parameter int bypass = 1
) (
  input  logic              clk,
  input  logic              rst,
  register_file_mp_if.slave bus
);

  localparam int aw = addr_width(nregs);

  logic [nread-1:0][aw-1:0]    ra;
  logic [nwrite-1:0][aw-1:0]   wa;
  logic [nwrite-1:0][xlen-1:0] wd;
  logic [nregs-1:0][xlen-1:0]  regs;
  logic [nregs-1:0]            busy;

  for (genvar i = 0; i < nread; i++) begin : g_ra
    assign ra[i] = aw'(port_field(max_flat'(bus.rs_addr), i, aw));
  end

  for (genvar j = 0; j < nwrite; j++) begin : g_wr
    assign wa[j] = aw'(port_field(max_flat'(bus.rd_addr), j, aw));
    assign wd[j] = xlen'(port_field(max_flat'(bus.rd_data), j, xlen));
  end

  regfile_scoreboard #(.nregs(nregs), .nwrite(nwrite), .aw(aw)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .write_en (bus.write_en),
    .wr_addr  (wa),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .busy     (busy),
    .rsv_ok   (bus.rsv_ok)
  );

  // Later loop iterations override earlier ones: highest port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int j = 0; j < nwrite; j++)
        if (bus.write_en[j] && (wa[j] != aw'(x0))) regs[wa[j]] <= wd[j];
    end
  end

  for (genvar i = 0; i < nread; i++) begin : g_rd
    logic [xlen-1:0] d;
    logic            b;
    always_comb begin
      d = regs[ra[i]];
      b = busy[ra[i]];
      if (bypass != 0)
        for (int j = 0; j < nwrite; j++)
          if (bus.write_en[j] && (wa[j] == ra[i])) begin
            d = wd[j];
            b = 1'b0;
          end
      if (ra[i] == aw'(x0)) begin
        d = '0;
        b = 1'b0;
      end
    end
    assign bus.rs_data[i*xlen +: xlen] = d;
    assign bus.rs_busy[i]              = b;
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam int XL = 64;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_mp_if #(.xlen(XL), .nregs(NR), .nread(2), .nwrite(2)) bus0 ();
  register_file_mp_if #(.xlen(XL), .nregs(NR), .nread(2), .nwrite(2)) bus1 ();

  register_file_mp #(.xlen(XL), .nregs(NR), .nread(2), .nwrite(2), .bypass(1)) dut_byp (
    .clk(clk), .rst(rst), .bus(bus0));
  register_file_mp #(.xlen(XL), .nregs(NR), .nread(2), .nwrite(2), .bypass(0)) dut_nobyp (
    .clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int               dut;
    string            tag;
    logic [1:0][63:0] d;
    logic [1:0]       b;
    logic             ok;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] mem[NR];
  bit          bz[NR];
  bit          mvalid = 0;

  task automatic step(input string tag, input bit r,
                      input logic [4:0] r0, input logic [4:0] r1,
                      input logic [4:0] w0, input logic [4:0] w1,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic [1:0] we, input bit rv, input logic [4:0] rva);
    logic [4:0]  wa[2];
    logic [63:0] wdat[2];
    bit          ok;
    wa[0] = w0; wa[1] = w1; wdat[0] = d0; wdat[1] = d1;
    rst = r;
    bus0.rs_addr = {r1, r0};  bus1.rs_addr = {r1, r0};
    bus0.rd_addr = {w1, w0};  bus1.rd_addr = {w1, w0};
    bus0.rd_data = {d1, d0};  bus1.rd_data = {d1, d0};
    bus0.write_en = we;       bus1.write_en = we;
    bus0.rsv_en = rv;         bus1.rsv_en = rv;
    bus0.rsv_addr = rva;      bus1.rsv_addr = rva;
    ok = !bz[rva] || (rva == 5'd0);
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e.dut = k; e.tag = tag; e.ok = ok;
        for (int p = 0; p < 2; p++) begin
          logic [4:0] a;
          a = (p == 0) ? r0 : r1;
          e.d[p] = mem[a];
          e.b[p] = bz[a];
          if (k == 0)
            for (int j = 0; j < 2; j++)
              if (we[j] && wa[j] == a) begin e.d[p] = wdat[j]; e.b[p] = 1'b0; end
          if (a == 5'd0) begin e.d[p] = '0; e.b[p] = 1'b0; end
        end
        q.push_back(e);
      end
    end
    // reference update for the coming edge
    if (r) begin
      for (int n = 0; n < NR; n++) begin mem[n] = '0; bz[n] = 1'b0; end
      mvalid = 1;
    end else begin
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j] != 5'd0) begin mem[wa[j]] = wdat[j]; bz[wa[j]] = 1'b0; end
      if (rv && ok && rva != 5'd0) bz[rva] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a0, input logic [4:0] a1);
    step(tag, 1'b0, a0, a1, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 1'b0, 5'd0);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [127:0] od;
      logic [1:0]   ob;
      logic         ook;
      e = q.pop_front();
      if (e.dut == 0) begin od = bus0.rs_data; ob = bus0.rs_busy; ook = bus0.rsv_ok; end
      else            begin od = bus1.rs_data; ob = bus1.rs_busy; ook = bus1.rsv_ok; end
      for (int p = 0; p < 2; p++) begin
        total++;
        if (od[p*64 +: 64] !== e.d[p]) begin
          bad++;
          $display("FAIL %s byp=%0d rs_data[%0d] got=%h exp=%h", e.tag, 1 - e.dut, p, od[p*64 +: 64], e.d[p]);
        end
        total++;
        if (ob[p] !== e.b[p]) begin
          bad++;
          $display("FAIL %s byp=%0d rs_busy[%0d] got=%b exp=%b", e.tag, 1 - e.dut, p, ob[p], e.b[p]);
        end
      end
      total++;
      if (ook !== e.ok) begin
        bad++;
        $display("FAIL %s byp=%0d rsv_ok got=%b exp=%b", e.tag, 1 - e.dut, ook, e.ok);
      end
    end
  end

  initial begin
    for (int n = 0; n < NR; n++) begin mem[n] = '0; bz[n] = 1'b0; end
    rst = 1'b1;
    bus0.rs_addr = '0; bus0.rd_addr = '0; bus0.rd_data = '0; bus0.write_en = '0;
    bus0.rsv_en = 1'b0; bus0.rsv_addr = '0;
    bus1.rs_addr = '0; bus1.rd_addr = '0; bus1.rd_data = '0; bus1.write_en = '0;
    bus1.rsv_en = 1'b0; bus1.rsv_addr = '0;
    @(posedge clk); #1;

    // reset with writes and a reserve pending: all ignored
    step("reset", 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 64'd10, 64'd10, 2'b11, 1'b1, 5'd6);
    step("reset", 1'b1, 5'd5, 5'd0, 5'd5, 5'd5, 64'd10, 64'd10, 2'b11, 1'b1, 5'd6);
    for (int n = 0; n < NR; n += 2) rd("reset_rd", 5'(n), 5'(n + 1));

    // fill: register n <- n+1, alternating ports; same-cycle read of n
    for (int n = 0; n < NR; n++) begin
      if (n % 2 == 0)
        step("fill", 1'b0, 5'(n), 5'(n), 5'(n), 5'd0, 64'(n + 1), 64'd0, 2'b01, 1'b0, 5'd0);
      else
        step("fill", 1'b0, 5'(n), 5'(n), 5'd0, 5'(n), 64'd0, 64'(n + 1), 2'b10, 1'b0, 5'd0);
    end
    for (int n = 0; n < NR; n++) rd("readback", 5'(n), 5'(n));

    // write conflict on x7: port 1 wins
    step("conflict", 1'b0, 5'd7, 5'd7, 5'd7, 5'd7, 64'hAA, 64'h55, 2'b11, 1'b0, 5'd0);
    rd("conflict_next", 5'd7, 5'd6);

    // scoreboard sequence
    step("rsv3", 1'b0, 5'd3, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 1'b1, 5'd3);
    step("rsv3_again", 1'b0, 5'd3, 5'd3, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 1'b1, 5'd3);
    step("wr3", 1'b0, 5'd3, 5'd2, 5'd3, 5'd0, 64'h1234, 64'd0, 2'b01, 1'b0, 5'd0);
    step("rsv0", 1'b0, 5'd3, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 1'b1, 5'd0);
    rd("after_rsv0", 5'd0, 5'd3);

    // reserve and write x9 together: busy stays set, data stored
    step("rsv_wr9", 1'b0, 5'd9, 5'd1, 5'd0, 5'd9, 64'd0, 64'hCAFE, 2'b10, 1'b1, 5'd9);
    rd("after_rsv_wr9", 5'd9, 5'd9);
    step("wr9_clear", 1'b0, 5'd9, 5'd0, 5'd9, 5'd0, 64'h77, 64'd0, 2'b01, 1'b0, 5'd0);
    rd("after_clear9", 5'd9, 5'd9);

    // mid-operation reset
    step("rsv4_wr2", 1'b0, 5'd2, 5'd4, 5'd2, 5'd0, 64'hFF, 64'd0, 2'b01, 1'b1, 5'd4);
    step("mid_rst", 1'b1, 5'd2, 5'd4, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 1'b0, 5'd0);
    rd("after_mid_rst", 5'd2, 5'd4);

    // randomized traffic, small address range half the time to force conflicts
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a[6];
      for (int k = 0; k < 6; k++)
        a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      step("random", ($urandom_range(0, 59) == 0), a[0], a[1], a[2], a[3],
           {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), a[4]);
    end

    @(negedge clk); #1;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read integer register file. Used by the pipelined core.
- Adds the following to the register file:
  - configurable read and write port counts;
  - optional same-cycle write-to-read bypass;
  - per-register busy scoreboard, so issue logic can detect RAW hazards on in-flight results.
- Sits between decode/issue (read, reserve) and writeback (write, clear).

Parameters:
- xlen, 64, data width of each register.
- nregs, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero.
- nread, 2, number of read ports (>=1).
- nwrite, 2, number of write ports (>=1).
- bypass, 1, 1 = read ports return same-cycle write data; 0 = read returns stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- rs_addr  in  nread*log2(nregs)  read addresses; port i occupies slice i.
- rs_data  out  nread*xlen  read data per port, combinational.
- rs_busy  out  nread  1 = addressed register has an outstanding reservation.
- rd_addr  in  nwrite*log2(nregs)  write addresses.
- rd_data  in  nwrite*xlen  write data.
- write_en  in  nwrite  per-port write enable; a write also clears the busy bit.
- rsv_en  in  1  reserve request: set busy bit of rsv_addr.
- rsv_addr  in  log2(nregs)  register to reserve.
- rsv_ok  out  1  combinational: rsv_en accepted (target not already busy, or target is x0).

Behaviour:
- Reset (rst=1 at rising edge):
  - all registers cleared to 0 and all busy bits cleared;
  - writes and reservations in that cycle are ignored;
  - reset mid-operation discards all pending reservations.
- Reads are combinational, zero latency.
  - Address 0 always reads 0 with busy=0, regardless of bypass.
  - bypass=1: if any enabled write port targets the read address this cycle, rs_data = that port's rd_data and rs_busy = 0.
  - bypass=0: rs_data = stored value and rs_busy = stored busy bit; a write becomes visible the cycle after the edge.
- Writes take effect at the rising edge when write_en[j]=1 and rst=0.
  - Writes to address 0 are discarded.
  - Multiple ports writing the same address in one cycle: the highest-index port wins, both for data and for bypass selection.
  - A write to a non-busy register is legal and updates the data; its busy bit stays 0.
- Scoreboard, one busy bit per register (bit 0 constant 0):
  - At the edge, busy[rsv_addr] is set if rsv_en && rsv_ok && rsv_addr != 0.
  - busy[rd_addr[j]] is cleared for each enabled write port j.
  - Reserve and a write to the same register in the same cycle: reserve wins, so the busy bit ends at 1 and the write data is still stored. This models a new producer issued as the old one retires.
  - rsv_ok = !busy[rsv_addr] || rsv_addr == 0 (WAW stall). When rsv_ok=0 there is no state change from the reservation.
- Width rules:
  - Addresses are log2(nregs) bits; no out-of-range addresses are possible.
  - Data is stored unmodified (no sign or zero extension).

Decomposition:
- Package regfile_pkg holds:
  - the localparam computing addr_w = $clog2(nregs);
  - the x0 index constant;
  - a function to slice a port field from a flattened vector.
- Sub-module regfile_scoreboard holds:
  - the busy-bit array, reserve/clear priority and rsv_ok;
  - the data array, bypass muxing and write priority, which stay in the top module.

Test Plan:
- Reset check: rst=1 for 2 cycles with write_en=all-ones, rd_addr=5, rd_data=10 -> every register reads 0 and every rs_busy reads 0 on all read ports.
- Fill and read back, with rst=0:
  - write register n with value n+1 for n=0..31, alternating ports 0 and 1;
  - reading x1..x31 returns n+1 on both read ports;
  - x0 reads 0.
- Write conflict and bypass: ports 0 and 1 both write x7, with 0xAA on port 0 and 0x55 on port 1.
  - bypass=1: same-cycle read of x7 = 0x55.
  - Next cycle: stored value = 0x55.
  - bypass=0: same-cycle read returns the old value.
- Scoreboard sequence:
  - reserve x3 -> rs_busy=1 next cycle;
  - second reserve of x3 -> rsv_ok=0;
  - write x3=0x1234 -> busy=0 and data=0x1234;
  - reserve x0 -> rsv_ok=1 and busy stays 0.
- Simultaneous reserve and write of x9 -> after the edge busy[9]=1 and data = the written value.
- Mid-operation reset: reserve x4 and write x2=0xFF, then assert rst for one cycle -> x2 = 0 and busy[4] = 0.
